// File: rtl/test_status_mmio.sv
// test_status_mmio: memory-mapped pass/fail/timeout reporter with signature
// checksum, RUN cycle counter and watchdog, sitting on the data-memory port.
module test_status_mmio #(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_3FF0,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
   input  logic        sys_clk,
   input  logic        sys_rstn,
   input  logic        mem_we,
   input  logic        mem_re,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        hit,
   output logic        test_done,
   output logic        test_pass,
   output logic        test_timeout,
   output logic [30:0] test_code,
   output logic [31:0] cycle_count,
   output logic [31:0] sig_checksum
);

   localparam int unsigned DataW = 32;
   localparam int unsigned CodeW = 31;

   localparam logic [1:0] OffTohost = 2'd0;
   localparam logic [1:0] OffSig    = 2'd1;
   localparam logic [1:0] OffCycle  = 2'd2;
   localparam logic [1:0] OffStatus = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_PASS    = 2'd1,
      ST_FAIL    = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [DataW-1:0]   cycle_q, cycle_d;
   logic [DataW-1:0]   sig_q, sig_d;
   logic [CodeW-1:0]   code_q, code_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;
   logic               tmo_q, tmo_d;
   logic [DataW-1:0]   rdata_q, rdata_d;

   logic [1:0]         offset_c;
   logic               wr_tohost_c;
   logic               wr_sig_c;
   logic               unused_addr_c;

   // Window decode: word offset within the 16-byte block; byte lanes ignored.
   assign hit           = (mem_addr[31:4] == BASE_ADDR[31:4]);
   assign offset_c      = mem_addr[3:2];
   assign unused_addr_c = ^mem_addr[1:0];
   assign wr_tohost_c   = mem_we && hit && (offset_c == OffTohost);
   assign wr_sig_c      = mem_we && hit && (offset_c == OffSig);

   // State and register flops, cleared asynchronously.
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         state_q <= ST_RUN;
         cycle_q <= '0;
         sig_q   <= '0;
         code_q  <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         tmo_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cycle_q <= cycle_d;
         sig_q   <= sig_d;
         code_q  <= code_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         tmo_q   <= tmo_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state: verdict FSM, counter, checksum fold and registered read mux.
   always_comb begin
      state_d = state_q;
      cycle_d = cycle_q;
      sig_d   = sig_q;
      code_d  = code_q;
      done_d  = done_q;
      pass_d  = pass_q;
      tmo_d   = tmo_q;
      rdata_d = '0;

      // Reads see pre-write values, so the mux uses only _q terms.
      if (mem_re && hit) begin
         case (offset_c)
            OffTohost: rdata_d = '0;
            OffSig:    rdata_d = sig_q;
            OffCycle:  rdata_d = cycle_q;
            OffStatus: rdata_d = done_q ? {1'b1, code_q[CodeW-2:0], pass_q} : '0;
            default:   rdata_d = '0;
         endcase
      end

      if (state_q == ST_RUN) begin
         cycle_d = cycle_q + DataW'(1);
         if (wr_sig_c) begin
            sig_d = {sig_q[DataW-2:0], sig_q[DataW-1]} ^ mem_wdata;
         end
         // A verdict write outranks the watchdog on the same cycle.
         if (wr_tohost_c && mem_wdata[0]) begin
            done_d = 1'b1;
            if (mem_wdata == DataW'(1)) begin
               state_d = ST_PASS;
               pass_d  = 1'b1;
            end else begin
               state_d = ST_FAIL;
               code_d  = mem_wdata[DataW-1:1];
            end
         end else if (cycle_q == (TIMEOUT_CYCLES - DataW'(1))) begin
            state_d = ST_TIMEOUT;
            done_d  = 1'b1;
            tmo_d   = 1'b1;
         end
      end
   end

   assign mem_rdata    = rdata_q;
   assign test_done    = done_q;
   assign test_pass    = pass_q;
   assign test_timeout = tmo_q;
   assign test_code    = code_q;
   assign cycle_count  = cycle_q;
   assign sig_checksum = sig_q;

endmodule

// File: tb/tb_test_status_mmio.sv
// tb_test_status_mmio: table-driven vectors plus hand sequences for the
// verdict FSM, watchdog collision and asynchronous reset; read data is
// checked through an expected-value queue.
module tb_test_status_mmio;

   localparam logic [31:0] BASE = 32'h0000_3FF0;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        mem_we = 1'b0;
   logic        mem_re = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [31:0] mem_rdata;
   logic        hit;
   logic        test_done;
   logic        test_pass;
   logic        test_timeout;
   logic [30:0] test_code;
   logic [31:0] cycle_count;
   logic [31:0] sig_checksum;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_q[$];

   test_status_mmio #(
      .BASE_ADDR      (BASE),
      .TIMEOUT_CYCLES (32'd20)
   ) dut (
      .sys_clk      (clk),
      .sys_rstn     (rstn),
      .mem_we       (mem_we),
      .mem_re       (mem_re),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .hit          (hit),
      .test_done    (test_done),
      .test_pass    (test_pass),
      .test_timeout (test_timeout),
      .test_code    (test_code),
      .cycle_count  (cycle_count),
      .sig_checksum (sig_checksum)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        hit;
      logic        done;
      logic        pass;
      logic        tmo;
      logic [30:0] code;
      logic [31:0] cyc;
      logic [31:0] sig;
      logic [31:0] rd;
   } vec_t;

   vec_t tbl[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_status(input string tag, input logic done, input logic pass,
                             input logic tmo, input logic [30:0] code,
                             input logic [31:0] cyc, input logic [31:0] sig);
      chk({tag, ".done"},  32'(test_done),    32'(done));
      chk({tag, ".pass"},  32'(test_pass),    32'(pass));
      chk({tag, ".tmo"},   32'(test_timeout), 32'(tmo));
      chk({tag, ".code"},  32'(test_code),    32'(code));
      chk({tag, ".cycle"}, cycle_count,       cyc);
      chk({tag, ".sig"},   sig_checksum,      sig);
   endtask

   // One bus cycle: drive at negedge, check hit, push expected read data,
   // then pop and compare after the sampling edge.
   task automatic issue(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_hit,
                        input logic [31:0] exp_rd);
      logic [31:0] e;
      mem_we    = we;
      mem_re    = re;
      mem_addr  = addr;
      mem_wdata = wdata;
      #1;
      if (we || re) chk("hit", 32'(hit), 32'(exp_hit));
      exp_q.push_back(exp_rd);
      @(posedge clk);
      @(negedge clk);
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL rdata: scoreboard empty");
      end else begin
         e = exp_q.pop_front();
         chk("rdata", mem_rdata, e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
   endtask

   // Reset held across two edges, released on a negedge.
   task automatic do_reset();
      mem_we = 1'b0;
      mem_re = 1'b0;
      mem_addr = '0;
      mem_wdata = '0;
      @(negedge clk);
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      exp_q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      //          we   re   addr          wdata          hit  dn   ps   to   code    cyc     sig            rd
      tbl[0]  = '{1'b1,1'b0,BASE+32'h4,  32'h1,         1'b1,1'b0,1'b0,1'b0,31'h0, 32'd1,  32'h1,         32'h0};
      tbl[1]  = '{1'b1,1'b0,BASE+32'h4,  32'h8000_0000, 1'b1,1'b0,1'b0,1'b0,31'h0, 32'd2,  32'h8000_0002, 32'h0};
      tbl[2]  = '{1'b1,1'b0,BASE+32'h4,  32'hFFFF_FFFF, 1'b1,1'b0,1'b0,1'b0,31'h0, 32'd3,  32'hFFFF_FFFA, 32'h0};
      tbl[3]  = '{1'b0,1'b1,BASE+32'h4,  32'h0,         1'b1,1'b0,1'b0,1'b0,31'h0, 32'd4,  32'hFFFF_FFFA, 32'hFFFF_FFFA};
      tbl[4]  = '{1'b1,1'b0,BASE,        32'h2,         1'b1,1'b0,1'b0,1'b0,31'h0, 32'd5,  32'hFFFF_FFFA, 32'h0};
      tbl[5]  = '{1'b1,1'b0,BASE,        32'h0,         1'b1,1'b0,1'b0,1'b0,31'h0, 32'd6,  32'hFFFF_FFFA, 32'h0};
      tbl[6]  = '{1'b1,1'b0,BASE+32'h10, 32'h1,         1'b0,1'b0,1'b0,1'b0,31'h0, 32'd7,  32'hFFFF_FFFA, 32'h0};
      tbl[7]  = '{1'b0,1'b1,BASE+32'h8,  32'h0,         1'b1,1'b0,1'b0,1'b0,31'h0, 32'd8,  32'hFFFF_FFFA, 32'd7};
      tbl[8]  = '{1'b1,1'b1,BASE+32'h4,  32'h1,         1'b1,1'b0,1'b0,1'b0,31'h0, 32'd9,  32'hFFFF_FFF4, 32'hFFFF_FFFA};
      tbl[9]  = '{1'b0,1'b1,BASE+32'hC,  32'h0,         1'b1,1'b0,1'b0,1'b0,31'h0, 32'd10, 32'hFFFF_FFF4, 32'h0};
      tbl[10] = '{1'b0,1'b0,32'h0,       32'h0,         1'b0,1'b0,1'b0,1'b0,31'h0, 32'd11, 32'hFFFF_FFF4, 32'h0};
      tbl[11] = '{1'b1,1'b0,BASE,        32'h2B,        1'b1,1'b1,1'b0,1'b0,31'h15,32'd12, 32'hFFFF_FFF4, 32'h0};
      tbl[12] = '{1'b0,1'b1,BASE+32'hC,  32'h0,         1'b1,1'b1,1'b0,1'b0,31'h15,32'd12, 32'hFFFF_FFF4, 32'h8000_002A};
      tbl[13] = '{1'b1,1'b0,BASE+32'h4,  32'h5,         1'b1,1'b1,1'b0,1'b0,31'h15,32'd12, 32'hFFFF_FFF4, 32'h0};
      tbl[14] = '{1'b1,1'b0,BASE,        32'h1,         1'b1,1'b1,1'b0,1'b0,31'h15,32'd12, 32'hFFFF_FFF4, 32'h0};
      tbl[15] = '{1'b0,1'b1,BASE,        32'h0,         1'b1,1'b1,1'b0,1'b0,31'h15,32'd12, 32'hFFFF_FFF4, 32'h0};
      tbl[16] = '{1'b0,1'b1,BASE+32'h24, 32'h0,         1'b0,1'b1,1'b0,1'b0,31'h15,32'd12, 32'hFFFF_FFF4, 32'h0};
      tbl[17] = '{1'b0,1'b1,BASE+32'h8,  32'h0,         1'b1,1'b1,1'b0,1'b0,31'h15,32'd12, 32'hFFFF_FFF4, 32'd12};

      // Reset state
      do_reset();
      chk_status("reset", 1'b0, 1'b0, 1'b0, 31'h0, 32'd0, 32'h0);
      chk("reset.rdata", mem_rdata, 32'h0);

      // Table: checksum, ignored TOHOST values, off-window, FAIL and frozen state
      for (int i = 0; i < 18; i++) begin
         issue(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata, tbl[i].hit, tbl[i].rd);
         chk_status($sformatf("vec%0d", i), tbl[i].done, tbl[i].pass, tbl[i].tmo,
                    tbl[i].code, tbl[i].cyc, tbl[i].sig);
      end

      // PASS on the 10th cycle, counter freezes, later store ignored
      do_reset();
      idle(9);
      issue(1'b1, 1'b0, BASE, 32'h1, 1'b1, 32'h0);
      chk_status("pass", 1'b1, 1'b1, 1'b0, 31'h0, 32'd10, 32'h0);
      idle(3);
      issue(1'b1, 1'b0, BASE, 32'h3, 1'b1, 32'h0);
      chk_status("pass_frozen", 1'b1, 1'b1, 1'b0, 31'h0, 32'd10, 32'h0);
      issue(1'b0, 1'b1, BASE+32'hC, 32'h0, 1'b1, 32'h8000_0001);
      issue(1'b0, 1'b1, BASE+32'h8, 32'h0, 1'b1, 32'd10);

      // Watchdog fires after 20 cycles
      do_reset();
      idle(19);
      chk_status("pre_tmo", 1'b0, 1'b0, 1'b0, 31'h0, 32'd19, 32'h0);
      idle(1);
      chk_status("tmo", 1'b1, 1'b0, 1'b1, 31'h0, 32'd20, 32'h0);
      idle(2);
      issue(1'b1, 1'b0, BASE, 32'h1, 1'b1, 32'h0);
      chk_status("tmo_frozen", 1'b1, 1'b0, 1'b1, 31'h0, 32'd20, 32'h0);
      issue(1'b0, 1'b1, BASE+32'hC, 32'h0, 1'b1, 32'h8000_0000);

      // PASS store on the watchdog cycle wins
      do_reset();
      idle(19);
      issue(1'b1, 1'b0, BASE, 32'h1, 1'b1, 32'h0);
      chk_status("collide", 1'b1, 1'b1, 1'b0, 31'h0, 32'd20, 32'h0);

      // Asynchronous reset between edges mid-RUN
      do_reset();
      issue(1'b1, 1'b0, BASE+32'h4, 32'h0000_ABCD, 1'b1, 32'h0);
      idle(5);
      issue(1'b0, 1'b1, BASE+32'h4, 32'h0, 1'b1, 32'h0000_ABCD);
      chk_status("pre_rst", 1'b0, 1'b0, 1'b0, 31'h0, 32'd7, 32'h0000_ABCD);
      #2 rstn = 1'b0;
      #1;
      chk_status("async_rst", 1'b0, 1'b0, 1'b0, 31'h0, 32'd0, 32'h0);
      chk("async_rst.rdata", mem_rdata, 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      exp_q.delete();
      idle(1);
      chk_status("restart", 1'b0, 1'b0, 1'b0, 31'h0, 32'd1, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
